// File: rtl/udp_rx_ctrl.sv
// udp_rx_ctrl: receive-side controller behind the GMII UDP receiver.
// It filters each datagram on its destination port. Accepted payloads are
// stored into a ring of fixed-size slots in internal RAM. One descriptor is
// queued per stored packet, and the CPU reads the payload and pops the descriptor.
//
// Optional feature macro: UDP_RX_CTRL_IRQ_EN adds a registered one-cycle irq
// pulse after every commit. Without it the CPU polls desc_valid.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rx_wr_en/rx_wr_data           payload word strobe and data (first byte in [31:24])
//   rx_pkt_done/rx_byte_num       last-word marker and payload byte count
//   rx_src_port/rx_dest_port      UDP ports, stable during the payload
//   cfg_en/cfg_port               receive enable, accepted dest port (0 = any)
//   buf_rd_addr/buf_rd_data       {slot,word} CPU read port, 1-cycle latency
//   desc_valid/desc_slot/desc_len/desc_src_port  head of descriptor queue
//   desc_pop                      free the head slot
//   drop_cnt                      saturating count of dropped datagrams
//   irq                           commit pulse (only with UDP_RX_CTRL_IRQ_EN)
module udp_rx_ctrl #(
  parameter int SLOTS      = 4,
  parameter int SLOT_WORDS = 64,
  localparam int AW = $clog2(SLOTS*SLOT_WORDS),
  localparam int SW = $clog2(SLOTS),
  localparam int WW = $clog2(SLOT_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_wr_en,
  input  logic [31:0]   rx_wr_data,
  input  logic          rx_pkt_done,
  input  logic [15:0]   rx_byte_num,
  input  logic [15:0]   rx_src_port,
  input  logic [15:0]   rx_dest_port,
  input  logic          cfg_en,
  input  logic [15:0]   cfg_port,
  input  logic [AW-1:0] buf_rd_addr,
  output logic [31:0]   buf_rd_data,
  output logic          desc_valid,
  output logic [SW-1:0] desc_slot,
  output logic [15:0]   desc_len,
  output logic [15:0]   desc_src_port,
  input  logic          desc_pop,
  output logic [15:0]   drop_cnt
`ifdef UDP_RX_CTRL_IRQ_EN
  ,
  output logic          irq
`endif
);

  typedef enum logic [1:0] {IDLE, RECV, DROP, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] wr_slot_q, rd_slot_q;
  logic [SW:0]   occ_q;
  logic [WW:0]   wptr_q, wptr_d;
  logic [15:0]   len_q, src_q;

  logic [31:0]   mem [SLOTS*SLOT_WORDS];
  logic [15:0]   dlen [SLOTS];
  logic [15:0]   dsrc [SLOTS];

  logic          accept, mem_we, latch, drop_inc, commit, pop;
  logic [AW-1:0] mem_waddr;

  // Room is judged on registered occupancy, so a slot freed by a pop is
  // only usable from the following cycle.
  assign accept = cfg_en && (cfg_port == 16'h0000 || rx_dest_port == cfg_port) &&
                  (occ_q < (SW+1)'(SLOTS));
  assign pop    = desc_pop && (occ_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    mem_we    = 1'b0;
    mem_waddr = {wr_slot_q, wptr_q[WW-1:0]};
    latch     = 1'b0;
    drop_inc  = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_wr_en) begin
          if (accept) begin
            mem_we    = 1'b1;
            mem_waddr = {wr_slot_q, WW'(0)};
            wptr_d    = (WW+1)'(1);
            if (rx_pkt_done) begin
              latch   = 1'b1;
              state_d = COMMIT;
            end else begin
              state_d = RECV;
            end
          end else if (rx_pkt_done) begin
            drop_inc = 1'b1;          // rejected single-word packet
          end else begin
            state_d = DROP;
          end
        end
      end
      RECV: begin
        if (rx_wr_en && wptr_q == (WW+1)'(SLOT_WORDS)) begin
          // Slot overflow: abandon the packet, slot stays uncommitted.
          if (rx_pkt_done) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = DROP;
          end
        end else begin
          if (rx_wr_en) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + (WW+1)'(1);
          end
          if (rx_pkt_done) begin
            latch   = 1'b1;
            state_d = COMMIT;
          end
        end
      end
      DROP: begin
        if (rx_pkt_done) begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_slot_q <= '0;
      rd_slot_q <= '0;
      occ_q     <= '0;
      len_q     <= '0;
      src_q     <= '0;
      drop_cnt  <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        dlen[i] <= '0;
        dsrc[i] <= '0;
      end
    end else begin
      if (latch) begin
        len_q <= rx_byte_num;
        src_q <= rx_src_port;
      end
      if (commit) begin
        dlen[wr_slot_q] <= len_q;
        dsrc[wr_slot_q] <= src_q;
        wr_slot_q       <= wr_slot_q + SW'(1);
      end
      if (pop) rd_slot_q <= rd_slot_q + SW'(1);
      case ({commit, pop})
        2'b10:   occ_q <= occ_q + (SW+1)'(1);
        2'b01:   occ_q <= occ_q - (SW+1)'(1);
        default: occ_q <= occ_q;
      endcase
      if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Payload RAM is never cleared. Writes are held off during reset so a
  // packet cut short by reset leaves no trace beyond its uncommitted slot.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= rx_wr_data;
  end

  // Read-before-write: a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (rst) buf_rd_data <= '0;
    else     buf_rd_data <= mem[buf_rd_addr];
  end

  assign desc_valid    = (occ_q != '0);
  assign desc_slot     = rd_slot_q;
  assign desc_len      = dlen[rd_slot_q];
  assign desc_src_port = dsrc[rd_slot_q];

`ifdef UDP_RX_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= (state_q == COMMIT);
  end
`endif

endmodule

// File: tb/tb_udp_rx_ctrl.sv
// Directed self-checking bench for udp_rx_ctrl (SLOTS=4, SLOT_WORDS=64).
module tb_udp_rx_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        rx_wr_en, rx_pkt_done, cfg_en, desc_pop;
  logic [31:0] rx_wr_data, buf_rd_data;
  logic [15:0] rx_byte_num, rx_src_port, rx_dest_port, cfg_port;
  logic [7:0]  buf_rd_addr;
  logic        desc_valid;
  logic [1:0]  desc_slot;
  logic [15:0] desc_len, desc_src_port, drop_cnt;
  int          passed = 0, total = 0, irq_cnt = 0;
`ifdef UDP_RX_CTRL_IRQ_EN
  logic        irq;
`endif

  udp_rx_ctrl dut (
    .clk(clk), .rst(rst),
    .rx_wr_en(rx_wr_en), .rx_wr_data(rx_wr_data), .rx_pkt_done(rx_pkt_done),
    .rx_byte_num(rx_byte_num), .rx_src_port(rx_src_port), .rx_dest_port(rx_dest_port),
    .cfg_en(cfg_en), .cfg_port(cfg_port),
    .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .desc_valid(desc_valid), .desc_slot(desc_slot), .desc_len(desc_len),
    .desc_src_port(desc_src_port), .desc_pop(desc_pop), .drop_cnt(drop_cnt)
`ifdef UDP_RX_CTRL_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

`ifdef UDP_RX_CTRL_IRQ_EN
  always @(posedge clk) if (irq === 1'b1) irq_cnt++;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rx_wr_en = 1'b0; rx_pkt_done = 1'b0; desc_pop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // n words, data base+i, done with the last word; optional pop during COMMIT.
  task automatic send(input int n, input logic [15:0] bytes, input logic [15:0] dest,
                      input logic [15:0] src, input logic [31:0] base, input bit pop_commit);
    rx_dest_port = dest;
    rx_src_port  = src;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_wr_en    = 1'b1;
      rx_wr_data  = base + 32'(i);
      rx_pkt_done = (i == n-1);
      rx_byte_num = (i == n-1) ? bytes : 16'd0;
    end
    @(posedge clk); #1;
    rx_wr_en = 1'b0; rx_pkt_done = 1'b0; desc_pop = pop_commit;
    @(posedge clk); #1;
    desc_pop = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_pop();
    @(posedge clk); #1 desc_pop = 1'b1;
    @(posedge clk); #1 desc_pop = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(posedge clk); #1 buf_rd_addr = a;
    @(posedge clk); #1 d = buf_rd_data;
  endtask

  initial begin
    logic [31:0] d;
    int irq0;
    rst = 1'b1; rx_wr_en = 1'b0; rx_pkt_done = 1'b0; desc_pop = 1'b0;
    rx_wr_data = '0; rx_byte_num = '0; rx_src_port = '0; rx_dest_port = '0;
    cfg_en = 1'b1; cfg_port = 16'h1234; buf_rd_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(desc_valid), 0);
    chk("rst_slot", 32'(desc_slot), 0);
    chk("rst_len", 32'(desc_len), 0);
    chk("rst_src", 32'(desc_src_port), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_rdata", buf_rd_data, 0);
    rst = 1'b0;

    // 1: 3-word accepted packet
    send(3, 16'd10, 16'h1234, 16'hAAAA, 32'h11000000, 1'b0);
    chk("t1_valid", 32'(desc_valid), 1);
    chk("t1_slot", 32'(desc_slot), 0);
    chk("t1_len", 32'(desc_len), 10);
    chk("t1_src", 32'(desc_src_port), 32'hAAAA);
    rd(8'd0, d); chk("t1_w0", d, 32'h11000000);
    rd(8'd1, d); chk("t1_w1", d, 32'h11000001);
    rd(8'd2, d); chk("t1_w2", d, 32'h11000002);

    // 2: wrong dest port is dropped, queue unchanged
    send(2, 16'd8, 16'h4321, 16'hBBBB, 32'h22000000, 1'b0);
    chk("t2_drop", 32'(drop_cnt), 1);
    chk("t2_len", 32'(desc_len), 10);

    // 3: ring fills at 4, fifth dropped; pop frees slot 0 for the next one
    do_reset();
    irq0 = irq_cnt;
    send(1, 16'd4,  16'h1234, 16'h0001, 32'h30000000, 1'b0);
    send(2, 16'd8,  16'h1234, 16'h0002, 32'h31000000, 1'b0);
    send(1, 16'd3,  16'h1234, 16'h0003, 32'h32000000, 1'b0);
    send(3, 16'd12, 16'h1234, 16'h0004, 32'h33000000, 1'b0);
    send(2, 16'd5,  16'h1234, 16'h0005, 32'h34000000, 1'b0);
    chk("t3_drop", 32'(drop_cnt), 1);
    chk("t3_head_len", 32'(desc_len), 4);
    do_pop();
    chk("t3_pop_slot", 32'(desc_slot), 1);
    chk("t3_pop_len", 32'(desc_len), 8);
    send(2, 16'd7, 16'h1234, 16'h5555, 32'h66000000, 1'b0);
    chk("t3_drop2", 32'(drop_cnt), 1);
    rd(8'd0, d); chk("t3_s0w0", d, 32'h66000000);
    rd(8'd1, d); chk("t3_s0w1", d, 32'h66000001);
    repeat (3) do_pop();
    chk("t3_wrap_slot", 32'(desc_slot), 0);
    chk("t3_wrap_len", 32'(desc_len), 7);
    chk("t3_wrap_src", 32'(desc_src_port), 32'h5555);
`ifdef UDP_RX_CTRL_IRQ_EN
    chk("t3_irq", 32'(irq_cnt - irq0), 5);
`endif

    // 4: 65-word overflow dropped; 64-word packet fits exactly
    do_reset();
    send(65, 16'd260, 16'h1234, 16'h0044, 32'h40000000, 1'b0);
    chk("t4_drop", 32'(drop_cnt), 1);
    chk("t4_valid0", 32'(desc_valid), 0);
    send(64, 16'd256, 16'h1234, 16'h0045, 32'h44000000, 1'b0);
    chk("t4_valid", 32'(desc_valid), 1);
    chk("t4_slot", 32'(desc_slot), 0);
    chk("t4_len", 32'(desc_len), 256);
    rd(8'd63, d); chk("t4_w63", d, 32'h4400003F);

    // 5: commit and pop together at occupancy 2
    do_reset();
    send(2, 16'd8, 16'h1234, 16'h00B0, 32'h50000000, 1'b0);
    send(1, 16'd4, 16'h1234, 16'h00B1, 32'h51000000, 1'b0);
    send(1, 16'd2, 16'h1234, 16'h00B2, 32'h52000000, 1'b1);
    chk("t5_slot", 32'(desc_slot), 1);
    chk("t5_src", 32'(desc_src_port), 32'h00B1);
    do_pop();
    chk("t5_valid1", 32'(desc_valid), 1);
    chk("t5_len2", 32'(desc_len), 2);
    do_pop();
    chk("t5_empty", 32'(desc_valid), 0);
    do_pop();
    chk("t5_pop_empty", 32'(desc_slot), 3);

    // 6: reset mid-RECV discards the packet and the drop count
    do_reset();
    cfg_en = 1'b0;
    send(1, 16'd4, 16'h1234, 16'h0060, 32'h60000000, 1'b0);
    chk("t6_drop_dis", 32'(drop_cnt), 1);
    cfg_en = 1'b1; cfg_port = 16'h0000;
    rx_dest_port = 16'h9999;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 rx_wr_en = 1'b1; rx_wr_data = 32'h61000000 + 32'(i);
    end
    @(posedge clk); #1 rx_wr_en = 1'b0;
    do_reset();
    chk("t6_valid", 32'(desc_valid), 0);
    chk("t6_drop", 32'(drop_cnt), 0);
    irq0 = irq_cnt;
    send(2, 16'd6, 16'h9999, 16'hC0DE, 32'h77000000, 1'b0);
    chk("t6_slot", 32'(desc_slot), 0);
    chk("t6_len", 32'(desc_len), 6);
    rd(8'd1, d); chk("t6_w1", d, 32'h77000001);
`ifdef UDP_RX_CTRL_IRQ_EN
    chk("t6_irq", 32'(irq_cnt - irq0), 1);
`endif
    // lone done in IDLE is ignored
    @(posedge clk); #1 rx_pkt_done = 1'b1;
    @(posedge clk); #1 rx_pkt_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_lone_done", 32'(drop_cnt), 0);
    chk("t6_lone_len", 32'(desc_len), 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
